wb_write_arbiter: RTL and testbench

Write-side arbiter for the 32x32 register file: merges the fixed-latency pipeline writeback stream with a long-latency (load-miss / multiply-divide) result stream onto the register file's single write port. Pipeline writes have absolute priority; long-latency results are buffered in a small FIFO and drained in idle slots. Drives the register file's RegWrite/A3/WD3/JAL inputs directly from registers. Exports a per-register busy vector for the hazard unit.

---
 rtl/wb_write_arbiter_pkg.sv | 12 +
 rtl/wb_write_arbiter_fifo.sv | 65 ++++++
 rtl/wb_write_arbiter.sv | 114 +++++++++++
 tb/tb_wb_write_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package wb_arb_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  localparam logic [4:0] LINK_REG = 5'd31;
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Long-latency result FIFO for the write arbiter; exports entry
// valid/address vectors so the top can build the busy scoreboard.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  wb_entry_t             din_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [DEPTH-1:0]      vld_o,
  output logic [DEPTH-1:0][4:0] addr_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
    else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  // An entry is live if its distance from the read pointer is below
  // the occupancy; pointer subtraction wraps naturally.
  always_comb begin
    logic [PW-1:0] off;
    vld_o  = '0;
    addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = PW'(i) - rd_q;
      vld_o[i]  = CW'(off) < cnt_q;
      addr_o[i] = mem_q[i].addr;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline first, buffered long-latency
// results in idle slots. Define WB_ARB_BYPASS_EN for empty-FIFO bypass.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          P_VALID,
  input  logic [4:0]    P_A,
  input  logic [31:0]   P_WD,
  input  logic          P_JAL,
  input  logic          L_VALID,
  output logic          L_READY,
  input  logic [4:0]    L_A,
  input  logic [31:0]   L_WD,
  output logic          RegWrite,
  output logic [4:0]    A3,
  output logic [31:0]   WD3,
  output logic          JAL,
  output logic [31:0]   BUSY,
  output logic [CW-1:0] PEND
);

  wb_entry_t            head;
  wb_entry_t            l_ent;
  logic [CW-1:0]        cnt;
  logic [DEPTH-1:0]     vld;
  logic [DEPTH-1:0][4:0] addrs;
  logic                 hs;
  logic                 pop;
  logic                 push;
  logic                 byp;

  logic                 rw_q;
  logic                 jal_q;
  logic [4:0]           a3_q;
  logic [31:0]          wd3_q;

  assign l_ent   = '{addr: L_A, data: L_WD};
  assign L_READY = (cnt != CW'(DEPTH)) && !RST;
  assign hs      = L_VALID && L_READY;
  assign pop     = !P_VALID && (cnt != '0);

`ifdef WB_ARB_BYPASS_EN
  assign byp = hs && !P_VALID && (cnt == '0);
`else
  assign byp = 1'b0;
`endif

  assign push = hs && !byp;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .din_i   (l_ent),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt),
    .vld_o   (vld),
    .addr_o  (addrs)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rw_q  <= 1'b0;
      jal_q <= 1'b0;
      a3_q  <= ZERO_REG;
      wd3_q <= '0;
    end else if (P_VALID && P_JAL) begin
      // Link writes go through the JAL strobe, not RegWrite.
      rw_q  <= 1'b0;
      jal_q <= 1'b1;
      a3_q  <= LINK_REG;
      wd3_q <= P_WD;
    end else if (P_VALID) begin
      rw_q  <= P_A != ZERO_REG;
      jal_q <= 1'b0;
      a3_q  <= P_A;
      wd3_q <= P_WD;
    end else if (pop) begin
      rw_q  <= head.addr != ZERO_REG;
      jal_q <= 1'b0;
      a3_q  <= head.addr;
      wd3_q <= head.data;
    end else if (byp) begin
      rw_q  <= L_A != ZERO_REG;
      jal_q <= 1'b0;
      a3_q  <= L_A;
      wd3_q <= L_WD;
    end else begin
      rw_q  <= 1'b0;
      jal_q <= 1'b0;
    end
  end

  always_comb begin
    BUSY = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) BUSY[addrs[i]] = 1'b1;
    end
    BUSY[0] = 1'b0;
  end

  assign RegWrite = rw_q;
  assign JAL      = jal_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign PEND     = cnt;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          P_VALID = 1'b0;
  logic [4:0]    P_A = '0;
  logic [31:0]   P_WD = '0;
  logic          P_JAL = 1'b0;
  logic          L_VALID = 1'b0;
  logic          L_READY;
  logic [4:0]    L_A = '0;
  logic [31:0]   L_WD = '0;
  logic          RegWrite;
  logic [4:0]    A3;
  logic [31:0]   WD3;
  logic          JAL;
  logic [31:0]   BUSY;
  logic [CW-1:0] PEND;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .P_VALID(P_VALID), .P_A(P_A), .P_WD(P_WD), .P_JAL(P_JAL),
    .L_VALID(L_VALID), .L_READY(L_READY), .L_A(L_A), .L_WD(L_WD),
    .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .JAL(JAL),
    .BUSY(BUSY), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        rw;
    logic        jal;
    logic [4:0]  a3;
    logic [31:0] wd3;
    int          pend;
    logic [31:0] busy;
  } exp_t;

  ent_t        mq[$];
  exp_t        expq[$];
  logic [4:0]  last_a3 = '0;
  logic [31:0] last_wd = '0;
  int          ncmp = 0;
  int          nbad = 0;

  task automatic cyc(input bit rst, input bit pv, input logic [4:0] pa,
                     input logic [31:0] pwd, input bit pj, input bit lv,
                     input logic [4:0] la, input logic [31:0] lwd);
    exp_t e;
    ent_t x;
    bit   hs;
    bit   byp;
    @(negedge CLK);
    RST = rst; P_VALID = pv; P_A = pa; P_WD = pwd; P_JAL = pj;
    L_VALID = lv; L_A = la; L_WD = lwd;
    hs  = lv && !rst && (mq.size() != DEPTH);
    byp = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    byp = hs && !pv && (mq.size() == 0);
`endif
    e.rw = 1'b0; e.jal = 1'b0;
    if (rst) begin
      mq.delete();
      last_a3 = '0; last_wd = '0;
    end else begin
      if (pv && pj) begin
        e.jal = 1'b1; last_a3 = 5'd31; last_wd = pwd;
      end else if (pv) begin
        e.rw = (pa != 0); last_a3 = pa; last_wd = pwd;
      end else if (mq.size() > 0) begin
        x = mq.pop_front();
        e.rw = (x.a != 0); last_a3 = x.a; last_wd = x.d;
      end else if (byp) begin
        e.rw = (la != 0); last_a3 = la; last_wd = lwd;
      end
      if (hs && !byp) begin
        x.a = la; x.d = lwd;
        mq.push_back(x);
      end
    end
    e.a3 = last_a3; e.wd3 = last_wd;
    e.pend = mq.size();
    e.busy = '0;
    foreach (mq[i]) e.busy[mq[i].a] = 1'b1;
    e.busy[0] = 1'b0;
    expq.push_back(e);
  endtask

  initial begin
    exp_t e;
    bit   rdy;
    forever begin
      @(posedge CLK);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        rdy = (e.pend != DEPTH) && !RST;
        ncmp++;
        if (RegWrite !== e.rw || JAL !== e.jal || A3 !== e.a3 ||
            WD3 !== e.wd3 || PEND !== CW'(e.pend) || BUSY !== e.busy ||
            L_READY !== rdy) begin
          nbad++;
          $display("FAIL cycle t=%0t: got rw=%b jal=%b a3=%0d wd=%h pend=%0d busy=%h rdy=%b, want rw=%b jal=%b a3=%0d wd=%h pend=%0d busy=%h rdy=%b",
                   $time, RegWrite, JAL, A3, WD3, PEND, BUSY, L_READY,
                   e.rw, e.jal, e.a3, e.wd3, e.pend, e.busy, rdy);
        end
      end
    end
  end

  initial begin
    int pprob;
    int n;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 32'h5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 32'h1234, 0, 0, 0, 0);
    cyc(0, 1, 7, 32'h400010, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h11, 0, 1, 8, 32'h88);
    cyc(0, 1, 2, 32'h22, 0, 1, 9, 32'h99);
    cyc(0, 1, 3, 32'h33, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 5'(i + 10), i, 0, 1, 5'(i + 20), 32'hA0 + i);
    cyc(0, 1, 14, 32'h1, 0, 1, 25, 32'hAA);
    cyc(0, 1, 15, 32'h2, 0, 1, 25, 32'hAA);
    cyc(0, 0, 0, 0, 0, 1, 25, 32'hAA);
    cyc(0, 0, 0, 0, 0, 1, 25, 32'hAA);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'hDEAD, 0, 1, 0, 32'hBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 4, i, 0, 1, 5'(i + 1), 32'hC0 + i);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 12, 32'h777);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 12; b++) begin
      pprob = (b % 3 == 0) ? 90 : (b % 3 == 1) ? 50 : 10;
      for (int i = 0; i < 50; i++)
        cyc($urandom_range(99) == 0, $urandom_range(99) < pprob,
            5'($urandom), $urandom, $urandom_range(7) == 0,
            $urandom_range(1), 5'($urandom), $urandom);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(posedge CLK);
      n++;
    end
    #3;
    if (expq.size() > 0) begin
      nbad++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
